// File: rtl/numlock_code_sender.sv
// Serialises a CODE_LEN-bit combination as U/Z key presses into the numlock SM, then reports Unlock as Pass.
// Optional macro NUMLOCK_CODE_SENDER_RETRY_EN adds one automatic retry after a timeout and the Retried output.
module numlock_code_sender #(
    parameter int CODE_LEN    = 4,
    parameter int PRESS_CYC   = 2,
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 8
) (
    input  logic                Clk,
    input  logic                reset,
    input  logic                Start,
    input  logic [CODE_LEN-1:0] Code,
    input  logic                Abort,
    input  logic                Unlock,
    output logic                U,
    output logic                Z,
    output logic                Busy,
    output logic                Done,
    output logic                Pass,
    output logic [2:0]          BitIdx
`ifdef NUMLOCK_CODE_SENDER_RETRY_EN
    ,
    output logic                Retried
`endif
);

    localparam int MAX_PG  = (PRESS_CYC > GAP_CYC) ? PRESS_CYC : GAP_CYC;
    localparam int MAX_CYC = (MAX_PG > TIMEOUT_CYC) ? MAX_PG : TIMEOUT_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] PRESS_LD   = CW'(PRESS_CYC - 1);
    localparam logic [CW-1:0] GAP_LD     = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] TIMEOUT_LD = CW'(TIMEOUT_CYC - 1);
    localparam logic [2:0]    LAST_IDX   = 3'(CODE_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS,
        GAP,
        WAIT,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      code_q, code_d;
    logic            pass_q, pass_d;
    logic            u_q, u_d;
    logic            z_q, z_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
`ifdef NUMLOCK_CODE_SENDER_RETRY_EN
    logic            retried_q, retried_d;
    logic            retry_gap_q, retry_gap_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        code_d    = code_q;
        pass_d    = pass_q;
`ifdef NUMLOCK_CODE_SENDER_RETRY_EN
        retried_d   = retried_q;
        retry_gap_d = retry_gap_q;
`endif

        case (state_q)
            IDLE: begin
                if (Start) begin
                    code_d                 = '0;
                    code_d[CODE_LEN-1:0]   = Code;
                    bit_idx_d              = LAST_IDX;
                    pass_d                 = 1'b0;
                    cnt_d                  = PRESS_LD;
                    state_d                = PRESS;
`ifdef NUMLOCK_CODE_SENDER_RETRY_EN
                    retried_d   = 1'b0;
                    retry_gap_d = 1'b0;
`endif
                end
            end
            PRESS: begin
                if (cnt_q == '0) begin
                    cnt_d   = GAP_LD;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
`ifdef NUMLOCK_CODE_SENDER_RETRY_EN
                end else if (retry_gap_q) begin
                    // Retry gap ends: replay the latched code from its first digit.
                    retry_gap_d = 1'b0;
                    bit_idx_d   = LAST_IDX;
                    cnt_d       = PRESS_LD;
                    state_d     = PRESS;
`endif
                end else if (bit_idx_q == '0) begin
                    cnt_d   = TIMEOUT_LD;
                    state_d = WAIT;
                end else begin
                    bit_idx_d = bit_idx_q - 3'd1;
                    cnt_d     = PRESS_LD;
                    state_d   = PRESS;
                end
            end
            WAIT: begin
                if (Unlock) begin
                    pass_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = DONE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
`ifdef NUMLOCK_CODE_SENDER_RETRY_EN
                end else if (!retried_q) begin
                    retried_d   = 1'b1;
                    retry_gap_d = 1'b1;
                    cnt_d       = GAP_LD;
                    state_d     = GAP;
`endif
                end else begin
                    pass_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Abort overrides whatever the active state decided, including a same-cycle Unlock.
        if (Abort && (state_q == PRESS || state_q == GAP || state_q == WAIT)) begin
            state_d = IDLE;
            pass_d  = 1'b0;
            cnt_d   = '0;
`ifdef NUMLOCK_CODE_SENDER_RETRY_EN
            retry_gap_d = 1'b0;
`endif
        end

        u_d    = (state_d == PRESS) &&  code_d[bit_idx_d];
        z_d    = (state_d == PRESS) && !code_d[bit_idx_d];
        busy_d = (state_d == PRESS) || (state_d == GAP) || (state_d == WAIT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            code_q    <= '0;
            pass_q    <= 1'b0;
            u_q       <= 1'b0;
            z_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef NUMLOCK_CODE_SENDER_RETRY_EN
            retried_q   <= 1'b0;
            retry_gap_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            code_q    <= code_d;
            pass_q    <= pass_d;
            u_q       <= u_d;
            z_q       <= z_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef NUMLOCK_CODE_SENDER_RETRY_EN
            retried_q   <= retried_d;
            retry_gap_q <= retry_gap_d;
`endif
        end
    end

    assign U      = u_q;
    assign Z      = z_q;
    assign Busy   = busy_q;
    assign Done   = done_q;
    assign Pass   = pass_q;
    assign BitIdx = bit_idx_q;
`ifdef NUMLOCK_CODE_SENDER_RETRY_EN
    assign Retried = retried_q;
`endif

endmodule

// File: tb/tb_numlock_code_sender.sv
// Directed bench for numlock_code_sender at default parameters (CODE_LEN=4, PRESS=2, GAP=2, TIMEOUT=8).
// Cycle c is the clock period following edge c-1; Start is sampled at edge 0.
module tb_numlock_code_sender;

    logic       Clk;
    logic       reset;
    logic       Start;
    logic [3:0] Code;
    logic       Abort;
    logic       Unlock;
    logic       U, Z, Busy, Done, Pass;
    logic [2:0] BitIdx;
`ifdef NUMLOCK_CODE_SENDER_RETRY_EN
    logic       Retried;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    numlock_code_sender #(
        .CODE_LEN   (4),
        .PRESS_CYC  (2),
        .GAP_CYC    (2),
        .TIMEOUT_CYC(8)
    ) dut (
        .Clk    (Clk),
        .reset  (reset),
        .Start  (Start),
        .Code   (Code),
        .Abort  (Abort),
        .Unlock (Unlock),
        .U      (U),
        .Z      (Z),
        .Busy   (Busy),
        .Done   (Done),
        .Pass   (Pass),
        .BitIdx (BitIdx)
`ifdef NUMLOCK_CODE_SENDER_RETRY_EN
        ,
        .Retried(Retried)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // U and Z must never be pressed together.
    always @(negedge Clk) begin
        if (!reset) check("u_and_z", 32'(U & Z), 32'd0);
    end

    // Expected {U,Z,Busy,Done,Pass,BitIdx[2:0]} for an un-aborted 4-digit attempt.
    function automatic logic [7:0] exp_vec(input logic [3:0] code, input int c,
                                           input int done_c, input logic pass_f);
        logic u, z, busy, done, pass, b;
        logic [2:0] idx;
        int d, ph;
        u = 0; z = 0; busy = 0; done = 0; pass = 0; idx = 3'd0;
        if (c <= 16) begin
            d   = (c - 1) / 4;
            ph  = (c - 1) % 4;
            idx = 3'(3 - d);
            b   = code[idx];
            u   = (ph < 2) &&  b;
            z   = (ph < 2) && !b;
            busy = 1;
        end else if (c < done_c) begin
            busy = 1;
        end else if (c == done_c) begin
            done = 1;
            pass = pass_f;
        end else begin
            pass = pass_f;
        end
        return {u, z, busy, done, pass, idx};
    endfunction

    // One attempt: Start at edge 0, then per-cycle checks/drives for cycles 1..last_c.
    task automatic attempt(input string name, input logic [3:0] code, input int unlock_c,
                           input int abort_c, input int restart_c, input int rst_c,
                           input int last_c, input int done_c, input logic pass_f);
        logic [7:0] e;
        Code  = code;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int c = 1; c <= last_c; c++) begin
            e = exp_vec(code, c, done_c, pass_f);
            if (rst_c > 0 && c > rst_c)
                check($sformatf("%s_c%0d", name, c), 32'({U, Z, Busy, Done, Pass, BitIdx}), 32'd0);
            else if (abort_c > 0 && c > abort_c)
                check($sformatf("%s_c%0d", name, c), 32'({U, Z, Busy, Done, Pass}), 32'd0);
            else
                check($sformatf("%s_c%0d", name, c), 32'({U, Z, Busy, Done, Pass, BitIdx}), 32'(e));
            Unlock = (c == unlock_c);
            Abort  = (c == abort_c);
            reset  = (c == rst_c);
            if (c == restart_c) begin
                Start = 1'b1;
                Code  = 4'b0110;
            end else begin
                Start = 1'b0;
                Code  = code;
            end
            tick();
        end
        Unlock = 0; Abort = 0; reset = 0; Start = 0;
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b1; Start = 0; Code = '0; Abort = 0; Unlock = 0;
        repeat (2) tick();
        check("reset_outs", 32'({U, Z, Busy, Done, Pass, BitIdx}), 32'd0);
`ifdef NUMLOCK_CODE_SENDER_RETRY_EN
        check("reset_retried", 32'(Retried), 32'd0);
`endif
        // Start/Code ignored while reset is held.
        Start = 1'b1; Code = 4'b1111;
        tick();
        check("reset_hold", 32'({U, Busy}), 32'd0);
        Start = 1'b0;
        reset = 1'b0;
        repeat (2) tick();

        attempt("ok1011",  4'b1011, 19, 0, 0, 0, 22, 20, 1'b1);
        attempt("ok0000",  4'b0000, 19, 0, 0, 0, 22, 20, 1'b1);
        attempt("restart", 4'b1011, 19, 0, 6, 0, 22, 20, 1'b1);
        attempt("abort10", 4'b1011,  0, 10, 0, 0, 25, 99, 1'b0);
        attempt("abunl",   4'b1011, 18, 18, 0, 0, 26, 99, 1'b0);
        attempt("rst12",   4'b1011,  0, 0, 0, 12, 14, 99, 1'b0);
        // Fresh attempt after reset restarts from the top digit.
        attempt("postrst", 4'b1011, 19, 0, 0, 0, 5, 20, 1'b1);
        repeat (20) tick();

`ifdef NUMLOCK_CODE_SENDER_RETRY_EN
        begin
            int done_at;
            attempt("tmo_a", 4'b1011, 0, 0, 0, 0, 24, 99, 1'b0);
            // attempt() already advanced 3 cycles past cycle 24: now in cycle 28.
            check("retry_retried", 32'(Retried), 32'd1);
            check("retry_u28", 32'({U, Z, Busy, BitIdx}), 32'b1_0_1_011);
            done_at = 0;
            for (int c = 28; c < 80 && done_at == 0; c++) begin
                if (Done) done_at = c;
                else tick();
            end
            check("retry_done_cycle", 32'(done_at), 32'd51);
            check("retry_pass", 32'(Pass), 32'd0);
            tick();
            check("retry_idle", 32'({Busy, Done, Retried}), 32'b001);
        end
`else
        attempt("tmo", 4'b1011, 0, 0, 0, 0, 27, 25, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
